serial_adder: RTL and testbench

Parametrised digit-serial adder, the sequential successor to the 4-bit ripple adder. It computes sum = a + b + cin over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle, LSB digit first.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Serves as the area-cheap arithmetic unit for the CPU datapath experiments and as the DUT for the next adder bench.

---
 rtl/adder_pkg.sv | 30 +++
 rtl/digit_adder.sv | 31 +++
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM encoding and parameter checks for the digit-serial adder
//
// Purpose: state encoding for serial_adder, a counter-width helper and a
// macro that rejects WIDTH/DIGIT combinations that do not split evenly.
// Ports: none (package).

`ifndef ADDER_PKG_MACROS
`define ADDER_PKG_MACROS
// Elaboration-time guard: WIDTH must be an exact multiple of DIGIT.
`define ADDER_CHECK_WIDTH(W, D) if (((W) % (D)) != 0) begin : g_bad_width $error("serial_adder: WIDTH must be a multiple of DIGIT"); end
`endif

package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Digit counter width; a single-digit adder still gets a 1-bit counter.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple-carry adder
//
// Purpose: adds one digit of each operand plus an incoming carry.
// Ports:
//   a, b  in  [DIGIT-1:0]  operand digits
//   cin   in  1            carry in
//   sum   out [DIGIT-1:0]  digit sum
//   cout  out 1            carry out of the top bit

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder with start/busy/done handshake
//
// Purpose: computes a + b + cin over WIDTH/DIGIT RUN cycles, LSB digit
// first, and reports carry-out and signed overflow.
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; accepted only in IDLE or DONE
//   a, b   in   WIDTH  operands, captured on accepted start
//   cin    in   1      carry in, captured on accepted start
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse after the result registers load
//   sum    out  WIDTH  result, held until the next completion
//   cout   out  1      carry out of bit WIDTH-1
//   ovf    out  1      signed overflow

module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  `ADDER_CHECK_WIDTH(WIDTH, DIGIT)

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_d;
  logic             w_c;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_d_top;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(NDIG - 1));

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a    (r_a_sh[DIGIT-1:0]),
    .b    (r_b_sh[DIGIT-1:0]),
    .cin  (r_carry),
    .sum  (w_d),
    .cout (w_c)
  );

  // New digit enters at the top of the result register; after NDIG shifts
  // the first (LSB) digit has reached bit 0.
  assign w_d_top    = WIDTH'(w_d) << (WIDTH - DIGIT);
  assign w_res_next = (r_res >> DIGIT) | w_d_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      // Operand sign bits are shifted out during RUN, so keep them for ovf.
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_a_sh  <= r_a_sh >> DIGIT;
      r_b_sh  <= r_b_sh >> DIGIT;
      r_res   <= w_res_next;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_c;
        r_ovf  <= (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (8/4 and 4/1 configurations)

module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         t;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_done8  = 0;
  int   n_done4  = 0;
  exp_t q8[$];
  exp_t q4[$];

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8)
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done8) begin
      exp_t e;
      n_done8++;
      check("busy8_at_done", {31'd0, busy8}, 32'd0);
      if (q8.size() == 0) begin
        check("done8_unexpected", 32'd1, {31'd0, busy8});
      end else begin
        e = q8.pop_front();
        check("sum8", {24'd0, sum8}, {24'd0, e.sum});
        check("cout8", {31'd0, cout8}, {31'd0, e.cout});
        check("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
        check("lat8", cyc - e.t, 32'd2);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      exp_t e;
      n_done4++;
      if (q4.size() == 0) begin
        check("done4_unexpected", 32'd1, {31'd0, busy4});
      end else begin
        e = q4.pop_front();
        check("sum4", {28'd0, sum4}, {24'd0, e.sum});
        check("cout4", {31'd0, cout4}, {31'd0, e.cout});
        check("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
        check("lat4", cyc - e.t, 32'd4);
      end
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    e.sum = es; e.cout = ec; e.ovf = eo; e.t = cyc;
    q8.push_back(e);
  endtask

  task automatic drain8();
    for (int i = 0; i < 20 && q8.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("drain8_timeout", q8.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic c);
    exp_t       e;
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    e.sum  = {4'd0, s[3:0]};
    e.cout = s[4];
    e.ovf  = (a[3] == b[3]) && (s[3] != a[3]);
    e.t    = cyc;
    q4.push_back(e);
  endtask

  task automatic drain4();
    for (int i = 0; i < 20 && q4.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("drain4_timeout", q4.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    check("rst_cout8", {31'd0, cout8}, 32'd0);
    check("rst_ovf8", {31'd0, ovf8}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_done4", {31'd0, done4}, 32'd0);
    check("rst_sum4", {28'd0, sum4}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic op with cycle-by-cycle handshake checks
    launch8(8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1);
    check("t1_busy_a", {31'd0, busy8}, 32'd1);
    check("t1_done_a", {31'd0, done8}, 32'd0);
    @(posedge clk); #1;
    check("t1_busy_b", {31'd0, busy8}, 32'd1);
    check("t1_done_b", {31'd0, done8}, 32'd0);
    @(posedge clk); #1;
    check("t1_busy_c", {31'd0, busy8}, 32'd0);
    check("t1_done_c", {31'd0, done8}, 32'd1);
    drain8();
    check("t1_done_clear", {31'd0, done8}, 32'd0);

    // Carry wrap
    launch8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drain8();
    launch8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    drain8();

    // Start while busy is ignored
    d0 = n_done8;
    launch8(8'h10, 8'h05, 1'b0, 8'h15, 1'b0, 1'b0);
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    drain8();
    repeat (4) @(posedge clk);
    #1;
    check("t3_one_done", n_done8 - d0, 32'd1);

    // Back-to-back: start held through DONE
    launch8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_done_first", {31'd0, done8}, 32'd1);
    @(posedge clk); #1;
    start8 = 1'b0;
    begin
      exp_t e;
      e.sum = 8'h80; e.cout = 1'b0; e.ovf = 1'b1; e.t = cyc;
      q8.push_back(e);
    end
    check("t4_busy_again", {31'd0, busy8}, 32'd1);
    check("t4_sum_held", {24'd0, sum8}, 32'h03);
    drain8();

    // Asynchronous reset mid-RUN
    d0 = n_done8;
    a8 = 8'h55; b8 = 8'hAA; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("t5_busy_pre", {31'd0, busy8}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy8}, 32'd0);
    check("t5_done", {31'd0, done8}, 32'd0);
    check("t5_sum", {24'd0, sum8}, 32'd0);
    check("t5_cout", {31'd0, cout8}, 32'd0);
    check("t5_ovf", {31'd0, ovf8}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_done", n_done8 - d0, 32'd0);
    launch8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);
    drain8();

    // Exhaustive bit-serial sweep
    d0 = n_done4;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          launch4(4'(ia), 4'(ib), 1'(ic));
          drain4();
        end
      end
    end
    check("t6_done_count", n_done4 - d0, 32'd512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
